sta_output_drain: RTL and testbench

STA_OUTPUT_DRAIN -- requirements
Module: sta_output_drain

---
 rtl/sta_output_drain.sv | 196 +++++++++++++++++++
 tb/tb_sta_output_drain.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sta_output_drain.sv
// ---------------------------------------------------------------------------
// sta_output_drain
//
// Snapshots the four accumulator rows of a 4x4 systolic array on a capture
// pulse and drains them one row per beat over a valid/ready stream. A capture
// that arrives while a drain is still in progress is dropped and flagged in a
// sticky overflow bit. The only exception is a capture in the same cycle as
// the final-row transfer: that capture is accepted back-to-back.
//
// Optional feature macro:
//   STA_DRAIN_RELU_EN - when defined, each output lane is clamped to
//                       max(value, 0) as it is loaded into the output
//                       register. The snapshot buffer always keeps the raw
//                       accumulator values.
//
// Reset is synchronous and active-low ('reset' sampled on the clk edge).
// ---------------------------------------------------------------------------
module sta_output_drain #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               capture,
    input  logic signed [31:0] C0 [0:N-1],
    input  logic signed [31:0] C1 [0:N-1],
    input  logic signed [31:0] C2 [0:N-1],
    input  logic signed [31:0] C3 [0:N-1],
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_row,
    output logic signed [31:0] out_data [0:N-1],
    output logic               out_last,
    output logic               busy,
    output logic               overflow,
    input  logic               clr_overflow
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [1:0] LAST_ROW = 2'd3;

    // Output lane transform: optional ReLU applied only on the way out.
`ifdef STA_DRAIN_RELU_EN
    function automatic logic signed [31:0] lane_out_f(input logic signed [31:0] v);
        if (v < 32'sd0) begin
            return 32'sd0;
        end else begin
            return v;
        end
    endfunction
`else
    function automatic logic signed [31:0] lane_out_f(input logic signed [31:0] v);
        return v;
    endfunction
`endif

    state_t             state_q, state_d;
    logic [1:0]         row_q, row_d;
    logic signed [31:0] buf_q      [0:N-1][0:N-1];
    logic signed [31:0] buf_d      [0:N-1][0:N-1];
    logic signed [31:0] out_data_q [0:N-1];
    logic signed [31:0] out_data_d [0:N-1];
    logic               overflow_q, overflow_d;

    logic               drain_s;
    logic               xfer_s;
    logic               last_xfer_s;
    logic               accept_s;
    logic               drop_s;

    // Handshake decode: a beat moves only when presented and accepted; a
    // capture is taken when idle or exactly on the final-row transfer.
    always_comb begin
        drain_s     = (state_q == ST_DRAIN);
        xfer_s      = drain_s && out_ready;
        last_xfer_s = xfer_s && (row_q == LAST_ROW);
        accept_s    = capture && (!drain_s || last_xfer_s);
        drop_s      = capture && drain_s && !last_xfer_s;
    end

    // Next-state logic for the FSM, row counter, snapshot, output data and
    // sticky overflow flag.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        buf_d      = buf_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (last_xfer_s && !capture) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_s) begin
            row_d = 2'd0;
        end else if (xfer_s) begin
            row_d = row_q + 2'd1;
        end else begin
            row_d = row_q;
        end

        if (accept_s) begin
            for (int i = 0; i < N; i++) begin
                buf_d[0][i] = C0[i];
                buf_d[1][i] = C1[i];
                buf_d[2][i] = C2[i];
                buf_d[3][i] = C3[i];
            end
        end else begin
            buf_d = buf_q;
        end

        // The output register is loaded with the row that will be presented
        // next cycle; a fresh capture always presents row 0 straight from
        // the inputs, so the read does not depend on the buffer next-state.
        if (state_d == ST_DRAIN) begin
            if (accept_s) begin
                for (int i = 0; i < N; i++) begin
                    out_data_d[i] = lane_out_f(C0[i]);
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    out_data_d[i] = lane_out_f(buf_q[row_d][i]);
                end
            end
        end else begin
            out_data_d = out_data_q;
        end

        // A dropped capture takes priority over a clear in the same cycle.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            row_q      <= 2'd0;
            overflow_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                out_data_q[r] <= 32'sd0;
                for (int i = 0; i < N; i++) begin
                    buf_q[r][i] <= 32'sd0;
                end
            end
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            overflow_q <= overflow_d;
            for (int r = 0; r < N; r++) begin
                out_data_q[r] <= out_data_d[r];
                for (int i = 0; i < N; i++) begin
                    buf_q[r][i] <= buf_d[r][i];
                end
            end
        end
    end

    // Outputs are direct decodes of registered state.
    always_comb begin
        out_valid = (state_q == ST_DRAIN);
        busy      = (state_q == ST_DRAIN);
        out_row   = (state_q == ST_DRAIN) ? row_q : 2'd0;
        out_last  = (state_q == ST_DRAIN) && (row_q == LAST_ROW);
        overflow  = overflow_q;
        for (int i = 0; i < N; i++) begin
            out_data[i] = out_data_q[i];
        end
    end

endmodule

// File: tb/tb_sta_output_drain.sv
// ---------------------------------------------------------------------------
// tb_sta_output_drain - directed self-checking bench for sta_output_drain.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Build with +define+STA_DRAIN_RELU_EN to check the ReLU variant.
// ---------------------------------------------------------------------------
module tb_sta_output_drain;

    logic               clk = 1'b0;
    logic               reset;
    logic               capture;
    logic signed [31:0] C0 [0:3];
    logic signed [31:0] C1 [0:3];
    logic signed [31:0] C2 [0:3];
    logic signed [31:0] C3 [0:3];
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_row;
    logic signed [31:0] out_data [0:3];
    logic               out_last;
    logic               busy;
    logic               overflow;
    logic               clr_overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [31:0] relu_exp [0:3];

    always #5 clk = ~clk;

    sta_output_drain #(.N(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .capture      (capture),
        .C0           (C0),
        .C1           (C1),
        .C2           (C2),
        .C3           (C3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row r lane i gets base + 4*r + i + 1 (base 0 gives 1..16).
    task automatic load(input int base);
        for (int i = 0; i < 4; i++) begin
            C0[i] = base + 0  + i + 1;
            C1[i] = base + 4  + i + 1;
            C2[i] = base + 8  + i + 1;
            C3[i] = base + 12 + i + 1;
        end
    endtask

    task automatic expect_beat(input string tag, input int base, input int r);
        check($sformatf("%s.valid", tag), {31'd0, out_valid}, 32'd1);
        check($sformatf("%s.busy", tag), {31'd0, busy}, 32'd1);
        check($sformatf("%s.row", tag), {30'd0, out_row}, r);
        check($sformatf("%s.last", tag), {31'd0, out_last}, (r == 3) ? 32'd1 : 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s.lane%0d", tag, i), out_data[i], base + 4 * r + i + 1);
        end
    endtask

    task automatic expect_idle(input string tag);
        check($sformatf("%s.valid", tag), {31'd0, out_valid}, 32'd0);
        check($sformatf("%s.busy", tag), {31'd0, busy}, 32'd0);
        check($sformatf("%s.row", tag), {30'd0, out_row}, 32'd0);
        check($sformatf("%s.last", tag), {31'd0, out_last}, 32'd0);
    endtask

    initial begin
`ifdef STA_DRAIN_RELU_EN
        relu_exp[0] = 32'sd0;
        relu_exp[1] = 32'sd0;
        relu_exp[2] = 32'sd7;
        relu_exp[3] = 32'sd0;
`else
        relu_exp[0] = -32'sd5;
        relu_exp[1] = 32'sd0;
        relu_exp[2] = 32'sd7;
        relu_exp[3] = 32'h8000_0000;
`endif
        reset        = 1'b0;
        capture      = 1'b0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        load(900);

        // Reset state
        tick();
        tick();
        expect_idle("rst");
        check("rst.ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst.lane%0d", i), out_data[i], 32'd0);
        end
        reset = 1'b1;
        tick();
        expect_idle("rst_rel");

        // Basic drain
        load(0);
        capture   = 1'b1;
        out_ready = 1'b1;
        tick();
        capture = 1'b0;
        for (int r = 0; r < 4; r++) begin
            expect_beat($sformatf("basic.r%0d", r), 0, r);
            tick();
        end
        expect_idle("basic.end");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic.hold%0d", i), out_data[i], 13 + i);
        end

        // Backpressure on row 1
        load(100);
        capture = 1'b1;
        tick();
        capture = 1'b0;
        expect_beat("bp.r0", 100, 0);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_beat($sformatf("bp.stall%0d", k), 100, 1);
            tick();
        end
        expect_beat("bp.r1", 100, 1);
        out_ready = 1'b1;
        tick();
        expect_beat("bp.r2", 100, 2);
        tick();
        expect_beat("bp.r3", 100, 3);
        tick();
        expect_idle("bp.end");

        // Overflow: capture on the row-1 beat is dropped
        load(200);
        capture = 1'b1;
        tick();
        capture = 1'b0;
        expect_beat("ovf.r0", 200, 0);
        tick();
        expect_beat("ovf.r1", 200, 1);
        load(300);
        capture = 1'b1;
        tick();
        capture = 1'b0;
        check("ovf.set", {31'd0, overflow}, 32'd1);
        expect_beat("ovf.r2", 200, 2);
        tick();
        expect_beat("ovf.r3", 200, 3);
        tick();
        expect_idle("ovf.end");
        check("ovf.sticky", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf.clr", {31'd0, overflow}, 32'd0);

        // Drop coincident with clear: set wins
        load(400);
        capture = 1'b1;
        tick();
        capture = 1'b0;
        expect_beat("ovfc.r0", 400, 0);
        load(450);
        capture      = 1'b1;
        clr_overflow = 1'b1;
        tick();
        capture      = 1'b0;
        clr_overflow = 1'b0;
        check("ovfc.setwins", {31'd0, overflow}, 32'd1);
        expect_beat("ovfc.r1", 400, 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovfc.clr", {31'd0, overflow}, 32'd0);
        expect_beat("ovfc.r2", 400, 2);
        tick();
        expect_beat("ovfc.r3", 400, 3);

        // Back-to-back: capture on the row-3 transfer
        load(500);
        capture = 1'b1;
        tick();
        capture = 1'b0;
        expect_beat("b2b.r0", 500, 0);
        check("b2b.ovf", {31'd0, overflow}, 32'd0);
        for (int r = 1; r < 4; r++) begin
            tick();
            expect_beat($sformatf("b2b.r%0d", r), 500, r);
        end
        tick();
        expect_idle("b2b.end");

        // ReLU / raw lane values
        load(700);
        C0[0] = -32'sd5;
        C0[1] = 32'sd0;
        C0[2] = 32'sd7;
        C0[3] = 32'sh8000_0000;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("relu.lane%0d", i), out_data[i], relu_exp[i]);
        end
        for (int r = 0; r < 4; r++) begin
            tick();
        end
        expect_idle("relu.end");

        // Reset mid-drain
        load(600);
        capture = 1'b1;
        tick();
        expect_beat("rstd.r0", 600, 0);
        tick();
        capture = 1'b0;
        check("rstd.ovf", {31'd0, overflow}, 32'd1);
        expect_beat("rstd.r1", 600, 1);
        tick();
        expect_beat("rstd.r2", 600, 2);
        reset   = 1'b0;
        capture = 1'b1;
        tick();
        expect_idle("rstd.abort");
        check("rstd.ovf0", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rstd.lane%0d", i), out_data[i], 32'd0);
        end
        reset   = 1'b1;
        capture = 1'b0;
        tick();
        expect_idle("rstd.after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
